// File: rtl/m1_bus_master.sv
// m1_bus_master: Avalon-MM slave that runs one asynchronous external bus
// cycle (SETUP -> PULSE -> HOLD) per accepted command. Chip select comes from
// avs_address[23:22]. The strobe pulse stretches while the synchronised
// ext_waitn is low.
// Optional feature macro: M1_BUS_TIMEOUT_EN. It bounds the ext_waitn stretch
// with a 20-bit counter. On expiry it returns 32'hDEADBEEF for reads and
// pulses timeout_err.
module m1_bus_master #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 6,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic        q_clock,
    input  logic        q_reset,
    input  logic [23:0] avs_address,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_write,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        avs_waitrequest,
    output logic [3:0]  ext_csn,
    output logic [21:0] ext_addr,
    output logic [3:0]  ext_ben,
    output logic        ext_rdn,
    output logic        ext_wrn,
    output logic [31:0] ext_dout,
    output logic        ext_doe,
    input  logic [31:0] ext_din,
    input  logic        ext_waitn,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Last value of the shared phase counter for each timed phase.
    localparam logic [5:0] SETUP_LAST = 6'(SETUP_CYC - 1);
    localparam logic [5:0] PULSE_LAST = 6'(PULSE_CYC - 1);
    localparam logic [5:0] HOLD_LAST  = 6'(HOLD_CYC - 1);

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic [5:0] cnt_r;
    logic [5:0] cnt_next_s;
    logic       is_read_r;
    logic       waitn_meta_r;
    logic       waitn_sync_r;
    logic       accept_s;
    logic       pulse_last_s;
    logic       waiting_s;
    logic       leave_pulse_s;
    logic       tmo_hit_s;

    // One-hot active-low chip select decode of the two top address bits.
    function automatic logic [3:0] cs_decode(input logic [1:0] sel);
        logic [3:0] csn;
        case (sel)
            2'd0:    csn = 4'b1110;
            2'd1:    csn = 4'b1101;
            2'd2:    csn = 4'b1011;
            2'd3:    csn = 4'b0111;
            default: csn = 4'b1111;
        endcase
        return csn;
    endfunction

    // A command is taken only in IDLE. A read wins when both strobes are high.
    assign accept_s     = (state_r == ST_IDLE) && (avs_read || avs_write);
    assign pulse_last_s = (cnt_r == PULSE_LAST);
    // The minimum pulse width has elapsed but the target still asks us to wait.
    assign waiting_s    = (state_r == ST_PULSE) && pulse_last_s && !waitn_sync_r;

    // Two-flop synchroniser for the asynchronous ext_waitn input; it idles high.
    always_ff @(posedge q_clock or posedge q_reset) begin
        if (q_reset) begin
            waitn_meta_r <= 1'b1;
            waitn_sync_r <= 1'b1;
        end else begin
            waitn_meta_r <= ext_waitn;
            waitn_sync_r <= waitn_meta_r;
        end
    end

`ifdef M1_BUS_TIMEOUT_EN
    logic [19:0] tmo_cnt_r;

    // Count the cycles spent stretching the strobe. Clear the count when not stretching.
    always_ff @(posedge q_clock or posedge q_reset) begin
        if (q_reset) begin
            tmo_cnt_r <= 20'd0;
        end else if (waiting_s) begin
            tmo_cnt_r <= tmo_cnt_r + 20'd1;
        end else begin
            tmo_cnt_r <= 20'd0;
        end
    end

    assign tmo_hit_s = waiting_s && (tmo_cnt_r == 20'hF_FFFF);

    // One-cycle abort flag, registered with the PULSE exit.
    always_ff @(posedge q_clock or posedge q_reset) begin
        if (q_reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit_s;
        end
    end
`else
    // No bound on the wait. The strobe stays stretched until ext_waitn returns.
    assign tmo_hit_s   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and phase-counter logic for the IDLE/SETUP/PULSE/HOLD sequence.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        leave_pulse_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_SETUP;
                    cnt_next_s   = 6'd0;
                end else begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 6'd0;
                end
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_next_s = ST_PULSE;
                    cnt_next_s   = 6'd0;
                end else begin
                    state_next_s = ST_SETUP;
                    cnt_next_s   = cnt_r + 6'd1;
                end
            end
            ST_PULSE: begin
                if (!pulse_last_s) begin
                    state_next_s = ST_PULSE;
                    cnt_next_s   = cnt_r + 6'd1;
                end else if (waitn_sync_r || tmo_hit_s) begin
                    state_next_s  = ST_HOLD;
                    cnt_next_s    = 6'd0;
                    leave_pulse_s = 1'b1;
                end else begin
                    // Stretch: keep the counter parked on the last counted cycle.
                    state_next_s = ST_PULSE;
                    cnt_next_s   = cnt_r;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 6'd0;
                end else begin
                    state_next_s = ST_HOLD;
                    cnt_next_s   = cnt_r + 6'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 6'd0;
            end
        endcase
    end

    // State and phase counter registers.
    always_ff @(posedge q_clock or posedge q_reset) begin
        if (q_reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 6'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Latch the accepted command straight into the bus output registers.
    // Hold them for the whole transfer and release them on the return to IDLE.
    always_ff @(posedge q_clock or posedge q_reset) begin
        if (q_reset) begin
            is_read_r <= 1'b0;
            ext_csn   <= 4'hF;
            ext_addr  <= 22'd0;
            ext_ben   <= 4'hF;
            ext_dout  <= 32'd0;
            ext_doe   <= 1'b0;
        end else if (accept_s) begin
            is_read_r <= avs_read;
            ext_csn   <= cs_decode(avs_address[23:22]);
            ext_addr  <= avs_address[21:0];
            ext_ben   <= ~avs_byteenable;
            ext_dout  <= avs_read ? 32'd0 : avs_writedata;
            ext_doe   <= !avs_read;
        end else if (state_next_s == ST_IDLE) begin
            is_read_r <= 1'b0;
            ext_csn   <= 4'hF;
            ext_addr  <= 22'd0;
            ext_ben   <= 4'hF;
            ext_dout  <= 32'd0;
            ext_doe   <= 1'b0;
        end else begin
            is_read_r <= is_read_r;
            ext_csn   <= ext_csn;
            ext_addr  <= ext_addr;
            ext_ben   <= ext_ben;
            ext_dout  <= ext_dout;
            ext_doe   <= ext_doe;
        end
    end

    // The read or write strobe is low exactly while the machine sits in PULSE.
    always_ff @(posedge q_clock or posedge q_reset) begin
        if (q_reset) begin
            ext_rdn <= 1'b1;
            ext_wrn <= 1'b1;
        end else begin
            ext_rdn <= !((state_next_s == ST_PULSE) && is_read_r);
            ext_wrn <= !((state_next_s == ST_PULSE) && !is_read_r);
        end
    end

    // Avalon response: busy outside IDLE. Read data is captured when PULSE ends.
    always_ff @(posedge q_clock or posedge q_reset) begin
        if (q_reset) begin
            avs_waitrequest   <= 1'b0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= 32'd0;
        end else begin
            avs_waitrequest   <= (state_next_s != ST_IDLE);
            avs_readdatavalid <= leave_pulse_s && is_read_r;
            if (leave_pulse_s && is_read_r) begin
                avs_readdata <= tmo_hit_s ? TIMEOUT_DATA : ext_din;
            end else begin
                avs_readdata <= avs_readdata;
            end
        end
    end

endmodule
